// File: rtl/image_dma_loader_if.sv
// rtl/image_dma_loader_if.sv - control, stream and data-memory signals of the image DMA loader
//
// Groups every handshake/bus signal of image_dma_loader.
//   control : start, mode (0 = LOAD, 1 = DUMP), base, length -> busy, done, error
//   load    : in_data, in_valid -> in_ready
//   dump    : out_data, out_valid <- out_ready
//   memory  : mem_we_n (low = write), mem_a, mem_din, mem_b -> mem_dob
// Modports: slave is the DMA engine view, master is the host/memory side view.
interface image_dma_loader_if #(
   parameter int AW = 32
);
   logic          start;
   logic          mode;
   logic [AW-1:0] base;
   logic [AW-1:0] length;
   logic          busy;
   logic          done;
   logic          error;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_ready;
   logic          mem_we_n;
   logic [AW-1:0] mem_a;
   logic [7:0]    mem_din;
   logic [AW-1:0] mem_b;
   logic [7:0]    mem_dob;

   modport slave (
      input  start, mode, base, length, in_data, in_valid, out_ready, mem_dob,
      output busy, done, error, in_ready, out_data, out_valid,
             mem_we_n, mem_a, mem_din, mem_b
   );

   modport master (
      output start, mode, base, length, in_data, in_valid, out_ready, mem_dob,
      input  busy, done, error, in_ready, out_data, out_valid,
             mem_we_n, mem_a, mem_din, mem_b
   );
endinterface

// File: rtl/image_dma_loader.sv
// rtl/image_dma_loader.sv - byte-stream DMA between host link and data memory
//
// LOAD streams host bytes into memory through the A/Din/WE port; DUMP reads
// bytes through the B/Dob port and streams them out.
//   clk_i  : system clock, posedge logic
//   rst_ni : asynchronous active-low reset
//   bus    : image_dma_loader_if.slave (control, load/dump streams, memory ports)
// Every output is registered except in_ready, which decodes the state.
module image_dma_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   image_dma_loader_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DUMP_RD,
      S_DUMP_OUT,
      S_FINISH
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] count_q, count_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [7:0]    out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          we_n_q, we_n_d;
   logic [AW-1:0] mem_a_q, mem_a_d;
   logic [7:0]    mem_din_q, mem_din_d;
   logic [AW-1:0] mem_b_q, mem_b_d;

   // One extra bit so base+length cannot wrap before the compare.
   logic [AW:0]   end_sum;
   logic          range_err;

   assign end_sum   = {1'b0, bus.base} + {1'b0, bus.length};
   assign range_err = end_sum > (AW+1)'(DEPTH);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      error_d     = error_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      we_n_d      = 1'b1;        // a write lasts exactly one cycle
      mem_a_d     = mem_a_q;
      mem_din_d   = mem_din_q;
      mem_b_d     = mem_b_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               error_d = 1'b0;
               addr_d  = bus.base;
               count_d = bus.length;
               if (bus.length == '0) begin
                  state_d = S_FINISH;
               end else if (range_err) begin
                  error_d = 1'b1;
                  state_d = S_FINISH;
               end else if (bus.mode) begin
                  // B is presented on entry so Dob is valid by the DUMP_RD exit edge.
                  mem_b_d = bus.base;
                  state_d = S_DUMP_RD;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (bus.in_valid) begin
               mem_a_d   = addr_q;
               mem_din_d = bus.in_data;
               we_n_d    = 1'b0;
               addr_d    = addr_q + AW'(1);
               count_d   = count_q - AW'(1);
               if (count_q == AW'(1)) begin
                  state_d = S_FINISH;
               end
            end
         end
         S_DUMP_RD: begin
            out_data_d  = bus.mem_dob;
            out_valid_d = 1'b1;
            state_d     = S_DUMP_OUT;
         end
         S_DUMP_OUT: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               addr_d      = addr_q + AW'(1);
               count_d     = count_q - AW'(1);
               if (count_q == AW'(1)) begin
                  state_d = S_FINISH;
               end else begin
                  mem_b_d = addr_q + AW'(1);
                  state_d = S_DUMP_RD;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      done_d = (state_d == S_FINISH);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         count_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         out_data_q  <= 8'h00;
         out_valid_q <= 1'b0;
         we_n_q      <= 1'b1;
         mem_a_q     <= '0;
         mem_din_q   <= 8'h00;
         mem_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         we_n_q      <= we_n_d;
         mem_a_q     <= mem_a_d;
         mem_din_q   <= mem_din_d;
         mem_b_q     <= mem_b_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;
   assign bus.in_ready  = (state_q == S_LOAD);
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.mem_we_n  = we_n_q;
   assign bus.mem_a     = mem_a_q;
   assign bus.mem_din   = mem_din_q;
   assign bus.mem_b     = mem_b_q;

endmodule
